instr_decode_unit: RTL and testbench



---
 rtl/instr_decode_unit.sv | 194 +++++++++++++++++++
 tb/tb_instr_decode_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_unit.sv
// rtl/instr_decode_unit.sv - registered handshaked instruction decoder with two-byte wide-immediate assembly
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (adds the illegal output and trap decode)
module instr_decode_unit #(
    parameter int INSTR_W  = 8,
    parameter int OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0] OP_LI  = 5'b00001,
    parameter logic [OPCODE_W-1:0] OP_LD  = 5'b00010,
    parameter logic [OPCODE_W-1:0] OP_ST  = 5'b00011,
    parameter logic [OPCODE_W-1:0] OP_LIX = 5'b00100
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTR_W-1:0]          instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPCODE_W-1:0]         opcode,
    output logic [INSTR_W-OPCODE_W-1:0] register,
    output logic [INSTR_W-1:0]          imm,
    output logic                        imm_wide,
    output logic                        is_alu_op,
    output logic                        is_mem_op,
    output logic                        mem_rw,
    output logic                        increment_pc
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    output logic                        illegal
`endif
);

    localparam int FIELD_W = INSTR_W - OPCODE_W;

    typedef enum logic {
        S_OP  = 1'b0,
        S_EXT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_out_valid;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [FIELD_W-1:0]    r_register;
    logic [INSTR_W-1:0]    r_imm;
    logic                  r_imm_wide;
    logic                  r_is_alu_op;
    logic                  r_is_mem_op;
    logic                  r_mem_rw;

    logic [OPCODE_W-1:0]   r_pend_opcode;
    logic [FIELD_W-1:0]    r_pend_register;

    logic                  w_in_ready;
    logic                  w_consume;
    logic                  w_load;
    logic                  w_pend_load;

    logic [OPCODE_W-1:0]   w_byte_opcode;
    logic [FIELD_W-1:0]    w_byte_field;

    logic [OPCODE_W-1:0]   w_dec_opcode;
    logic [FIELD_W-1:0]    w_dec_register;
    logic [INSTR_W-1:0]    w_dec_imm;
    logic                  w_dec_imm_wide;
    logic                  w_dec_is_alu_op;
    logic                  w_dec_is_mem_op;
    logic                  w_dec_mem_rw;

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                  r_illegal;
    logic                  w_dec_illegal;
`endif

    // A byte may only be taken when the output register is empty or being drained this cycle.
    assign w_in_ready    = !r_out_valid || out_ready;
    assign w_consume     = in_valid && w_in_ready;
    assign w_byte_opcode = instr[INSTR_W-1 -: OPCODE_W];
    assign w_byte_field  = instr[FIELD_W-1:0];

    // Next-state logic: decide whether the consumed byte loads the output or is held as a pending LIX head.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_pend_load = 1'b0;
        if (w_consume) begin
            case (r_state)
                S_OP: begin
                    if (w_byte_opcode == OP_LIX) begin
                        w_pend_load = 1'b1;
                        w_state_nxt = S_EXT;
                    end else begin
                        w_load = 1'b1;
                    end
                end
                S_EXT: begin
                    w_load      = 1'b1;
                    w_state_nxt = S_OP;
                end
                default: w_state_nxt = S_OP;
            endcase
        end
    end

    // Field decode: in S_EXT the opcode/register come from the pending head and the byte is the immediate.
    always_comb begin
        w_dec_opcode    = w_byte_opcode;
        w_dec_register  = w_byte_field;
        w_dec_imm       = {{OPCODE_W{1'b0}}, w_byte_field};
        w_dec_imm_wide  = 1'b0;
        if (r_state == S_EXT) begin
            w_dec_opcode   = r_pend_opcode;
            w_dec_register = r_pend_register;
            w_dec_imm      = instr;
            w_dec_imm_wide = 1'b1;
        end
        w_dec_is_alu_op = w_dec_opcode[OPCODE_W-1];
        w_dec_is_mem_op = (w_dec_opcode == OP_LD) || (w_dec_opcode == OP_ST);
        w_dec_mem_rw    = w_dec_is_mem_op && w_dec_opcode[0];
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    // Any non-ALU opcode outside the known set traps; class flags are already 0 for these codes.
    always_comb begin
        w_dec_illegal = !w_dec_opcode[OPCODE_W-1]
                        && (w_dec_opcode != '0)
                        && (w_dec_opcode != OP_LI)
                        && (w_dec_opcode != OP_LD)
                        && (w_dec_opcode != OP_ST)
                        && (w_dec_opcode != OP_LIX);
    end
`endif

    // State register and pending LIX head; reset discards any half-assembled instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_OP;
            r_pend_opcode   <= '0;
            r_pend_register <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pend_load) begin
                r_pend_opcode   <= w_byte_opcode;
                r_pend_register <= w_byte_field;
            end
        end
    end

    // Output register: a load wins over a drain; fields change only on load so a stalled result stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_register  <= '0;
            r_imm       <= '0;
            r_imm_wide  <= 1'b0;
            r_is_alu_op <= 1'b0;
            r_is_mem_op <= 1'b0;
            r_mem_rw    <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_illegal   <= 1'b0;
`endif
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_dec_opcode;
            r_register  <= w_dec_register;
            r_imm       <= w_dec_imm;
            r_imm_wide  <= w_dec_imm_wide;
            r_is_alu_op <= w_dec_is_alu_op;
            r_is_mem_op <= w_dec_is_mem_op;
            r_mem_rw    <= w_dec_mem_rw;
`ifdef DECODE_ILLEGAL_TRAP_EN
            r_illegal   <= w_dec_illegal;
`endif
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready     = w_in_ready;
    assign increment_pc = w_consume;
    assign out_valid    = r_out_valid;
    assign opcode       = r_opcode;
    assign register     = r_register;
    assign imm          = r_imm;
    assign imm_wide     = r_imm_wide;
    assign is_alu_op    = r_is_alu_op;
    assign is_mem_op    = r_is_mem_op;
    assign mem_rw       = r_mem_rw;
`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal      = r_illegal;
`endif

endmodule

// File: tb/tb_instr_decode_unit.sv
// tb/tb_instr_decode_unit.sv - self-checking bench for instr_decode_unit against a transaction-level model
module tb_instr_decode_unit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] instr;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] opcode;
    logic [2:0] register;
    logic [7:0] imm;
    logic       imm_wide;
    logic       is_alu_op;
    logic       is_mem_op;
    logic       mem_rw;
    logic       increment_pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    instr_decode_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode       (opcode),
        .register     (register),
        .imm          (imm),
        .imm_wide     (imm_wide),
        .is_alu_op    (is_alu_op),
        .is_mem_op    (is_mem_op),
        .mem_rw       (mem_rw),
        .increment_pc (increment_pc)
`ifdef DECODE_ILLEGAL_TRAP_EN
        ,
        .illegal      (illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int op;
        int rg;
        int imm;
        bit wide;
        bit alu;
        bit mem;
        bit rw;
        bit ill;
    } dec_t;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   pc_count = 0;

    bit   m_known  = 0;
    bit   m_valid  = 0;
    bit   m_pend   = 0;
    int   m_pend_byte = 0;
    dec_t m_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic dec_t decode(input int op_byte, input int ext, input bit wide);
        dec_t d;
        d.op   = op_byte / 8;
        d.rg   = op_byte % 8;
        d.imm  = wide ? ext : (op_byte % 8);
        d.wide = wide;
        d.alu  = (d.op >= 16);
        d.mem  = (d.op == 2) || (d.op == 3);
        d.rw   = (d.op == 3);
        d.ill  = (d.op < 16) && (d.op > 4);
        return d;
    endfunction

    function automatic dec_t zero_dec();
        dec_t d;
        d.op = 0; d.rg = 0; d.imm = 0;
        d.wide = 0; d.alu = 0; d.mem = 0; d.rw = 0; d.ill = 0;
        return d;
    endfunction

    task automatic check_outputs();
        bit exp_rdy;
        exp_rdy = !m_valid || out_ready;
        if (increment_pc === 1'b1) pc_count++;
        if (m_known) begin
            check("in_ready", in_ready, exp_rdy);
            check("increment_pc", increment_pc, in_valid && exp_rdy);
            check("out_valid", out_valid, m_valid);
            check("opcode", opcode, m_out.op);
            check("register", register, m_out.rg);
            check("imm", imm, m_out.imm);
            check("imm_wide", imm_wide, m_out.wide);
            check("is_alu_op", is_alu_op, m_out.alu);
            check("is_mem_op", is_mem_op, m_out.mem);
            check("mem_rw", mem_rw, m_out.rw);
`ifdef DECODE_ILLEGAL_TRAP_EN
            check("illegal", illegal, m_out.ill);
`endif
        end
    endtask

    task automatic model_update(input bit rst, input bit v, input int b, input bit ordy);
        bit consume;
        if (rst) begin
            m_known = 1;
            m_valid = 0;
            m_pend  = 0;
            m_out   = zero_dec();
        end else begin
            consume = v && (!m_valid || ordy);
            if (m_valid && ordy) m_valid = 0;
            if (consume) begin
                if (m_pend) begin
                    m_out   = decode(m_pend_byte, b, 1);
                    m_valid = 1;
                    m_pend  = 0;
                end else if (b / 8 == 4) begin
                    m_pend      = 1;
                    m_pend_byte = b;
                end else begin
                    m_out   = decode(b, 0, 0);
                    m_valid = 1;
                end
            end
        end
    endtask

    task automatic do_cycle(input bit rst, input bit v, input logic [7:0] b, input bit ordy);
        reset     = rst;
        in_valid  = v;
        instr     = b;
        out_ready = ordy;
        #1;
        check_outputs();
        model_update(rst, v, int'(b), ordy);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bit   rv;
        bit   vv;
        bit   ov;
        logic [7:0] bb;
        m_out     = zero_dec();
        reset     = 1'b1;
        in_valid  = 1'b0;
        instr     = 8'h00;
        out_ready = 1'b1;
        @(negedge clk);
        do_cycle(1, 0, 8'h00, 1);
        do_cycle(1, 0, 8'h00, 1);

        // reset, then idle
        do_cycle(0, 0, 8'h00, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_opcode", opcode, 0);
        check("rst_imm", imm, 0);

        // LD r5
        pc_count = 0;
        do_cycle(0, 1, 8'b00010_101, 1);
        check("ld_opcode", opcode, 2);
        check("ld_register", register, 5);
        check("ld_is_mem", is_mem_op, 1);
        check("ld_mem_rw", mem_rw, 0);
        check("ld_pc_pulses", pc_count, 1);

        // LIX with two idle cycles before the extension byte
        pc_count = 0;
        do_cycle(0, 1, 8'b00100_011, 1);
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 1, 8'hA7, 1);
        check("lix_imm", imm, 8'hA7);
        check("lix_wide", imm_wide, 1);
        check("lix_register", register, 3);
        check("lix_out_valid", out_valid, 1);
        check("lix_pc_pulses", pc_count, 2);

        // ST r1 then LI 6 stalled by out_ready=0
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 1, 8'b00011_001, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 8'b00001_110, 0);
        check("stall_in_ready", in_ready, 0);
        check("stall_opcode", opcode, 3);
        check("stall_mem_rw", mem_rw, 1);
        do_cycle(0, 1, 8'b00001_110, 1);
        check("li_opcode", opcode, 1);
        check("li_imm", imm, 6);
        check("li_wide", imm_wide, 0);
        check("li_out_valid", out_valid, 1);

        // reset in the middle of a LIX
        do_cycle(0, 0, 8'h00, 1);
        do_cycle(0, 1, 8'b00100_101, 1);
        do_cycle(1, 0, 8'h00, 1);
        do_cycle(0, 1, 8'b00001_010, 1);
        check("rstlix_opcode", opcode, 1);
        check("rstlix_imm", imm, 2);
        check("rstlix_wide", imm_wide, 0);

        // opcode 7: trap or NOP depending on build
        do_cycle(0, 1, 8'b00111_000, 1);
        check("op7_opcode", opcode, 7);
        check("op7_alu", is_alu_op, 0);
        check("op7_mem", is_mem_op, 0);
        check("op7_rw", mem_rw, 0);
`ifdef DECODE_ILLEGAL_TRAP_EN
        check("op7_illegal", illegal, 1);
`endif

        // randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 99) == 0);
            vv = ($urandom_range(0, 9) < 7);
            ov = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0) bb = {5'b00100, 3'($urandom_range(0, 7))};
            else bb = 8'($urandom);
            do_cycle(rv, vv, bb, ov);
        end
        do_cycle(0, 0, 8'h00, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
